// File: rtl/dram_pad_cal_sched_if.sv
// Calibration-code handshake and pad-side signals of one DRAM pad group.
interface dram_pad_cal_sched_if;
  logic       cal_req;
  logic [7:0] cal_cbu;
  logic [7:0] cal_cbd;
  logic [7:0] cal_vref;
  logic       pad_oe;
  logic       hold;
  logic [7:0] cbu;
  logic [7:0] cbd;
  logic [7:0] vrefcode;
  logic       cal_ack;
  logic       upd_busy;
  logic       forced;

  modport master (
    output cal_req, cal_cbu, cal_cbd, cal_vref, pad_oe, hold,
    input  cbu, cbd, vrefcode, cal_ack, upd_busy, forced
  );

  modport slave (
    input  cal_req, cal_cbu, cal_cbd, cal_vref, pad_oe, hold,
    output cbu, cbd, vrefcode, cal_ack, upd_busy, forced
  );
endinterface

// File: rtl/dram_pad_cal_sched.sv
// Applies captured cbu/cbd/vref codes in a pad-quiet window (forced after MAX_WAIT), settles, then acks.
// `DRAM_CAL_STEP_EN: each APPLY moves every code by at most 1 LSB and loops until all match the shadow.
module dram_pad_cal_sched #(
  parameter int         IDLE_CYC   = 4,
  parameter int         SETTLE_CYC = 8,
  parameter int         MAX_WAIT   = 255,
  parameter logic [7:0] RST_CBU    = 8'h0F,
  parameter logic [7:0] RST_CBD    = 8'h0F,
  parameter logic [7:0] RST_VREF   = 8'h80
) (
  input logic                 rclk,
  input logic                 arst,
  dram_pad_cal_sched_if.slave bus
);

  localparam int IW = $clog2(IDLE_CYC + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);

  localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_CYC - 1);
  localparam logic [WW-1:0] WAIT_LAST   = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] WAIT_SAT    = WW'(MAX_WAIT);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_WIN,
    S_APPLY,
    S_SETTLE,
    S_ACK
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [7:0]    sh_cbu_q, sh_cbu_d;
  logic [7:0]    sh_cbd_q, sh_cbd_d;
  logic [7:0]    sh_vref_q, sh_vref_d;
  logic [7:0]    cbu_q, cbu_d;
  logic [7:0]    cbd_q, cbd_d;
  logic [7:0]    vref_q, vref_d;
  logic          forced_q, forced_d;
  logic          quiet;

`ifdef DRAM_CAL_STEP_EN
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction
`endif

  assign quiet = !bus.pad_oe && !bus.hold;

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;
    sh_cbu_d     = sh_cbu_q;
    sh_cbd_d     = sh_cbd_q;
    sh_vref_d    = sh_vref_q;
    cbu_d        = cbu_q;
    cbd_d        = cbd_q;
    vref_d       = vref_q;
    forced_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cal_req) begin
          sh_cbu_d   = bus.cal_cbu;
          sh_cbd_d   = bus.cal_cbd;
          sh_vref_d  = bus.cal_vref;
          idle_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = S_WAIT_WIN;
        end
      end

      S_WAIT_WIN: begin
        idle_cnt_d = quiet ? idle_cnt_q + 1'b1 : '0;
        wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? WAIT_SAT : wait_cnt_q + 1'b1;
        // The timeout counts the current cycle, so APPLY lands right after MAX_WAIT waiting cycles.
        if (quiet && idle_cnt_q == IDLE_LAST) begin
          state_d = S_APPLY;
        end else if (wait_cnt_q >= WAIT_LAST && !bus.hold) begin
          state_d  = S_APPLY;
          forced_d = 1'b1;
        end
      end

      S_APPLY: begin
`ifdef DRAM_CAL_STEP_EN
        cbu_d  = step_toward(cbu_q, sh_cbu_q);
        cbd_d  = step_toward(cbd_q, sh_cbd_q);
        vref_d = step_toward(vref_q, sh_vref_q);
`else
        cbu_d  = sh_cbu_q;
        cbd_d  = sh_cbd_q;
        vref_d = sh_vref_q;
`endif
        settle_cnt_d = '0;
        state_d      = S_SETTLE;
      end

      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (settle_cnt_q == SETTLE_LAST) begin
`ifdef DRAM_CAL_STEP_EN
          if ({cbu_q, cbd_q, vref_q} != {sh_cbu_q, sh_cbd_q, sh_vref_q}) begin
            idle_cnt_d = '0;
            wait_cnt_d = '0;
            state_d    = S_WAIT_WIN;
          end else begin
            state_d = S_ACK;
          end
`else
          state_d = S_ACK;
`endif
        end
      end

      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      state_q      <= S_IDLE;
      idle_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      settle_cnt_q <= '0;
      sh_cbu_q     <= '0;
      sh_cbd_q     <= '0;
      sh_vref_q    <= '0;
      cbu_q        <= RST_CBU;
      cbd_q        <= RST_CBD;
      vref_q       <= RST_VREF;
      forced_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      sh_cbu_q     <= sh_cbu_d;
      sh_cbd_q     <= sh_cbd_d;
      sh_vref_q    <= sh_vref_d;
      cbu_q        <= cbu_d;
      cbd_q        <= cbd_d;
      vref_q       <= vref_d;
      forced_q     <= forced_d;
    end
  end

  assign bus.cbu      = cbu_q;
  assign bus.cbd      = cbd_q;
  assign bus.vrefcode = vref_q;
  assign bus.cal_ack  = (state_q == S_ACK);
  assign bus.upd_busy = (state_q != S_IDLE);
  assign bus.forced   = forced_q;

endmodule
